// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel debouncer.
package debounce_pkg;

  localparam int MAX_CHANNELS    = 32;
  localparam int MIN_COUNTER_MAX = 2;
  localparam int MAX_COUNTER_MAX = 65536;

  // Width of a stable counter that only ever reaches counter_max-1.
  function automatic int cnt_w(input int counter_max);
    return (counter_max <= 2) ? 1 : $clog2(counter_max);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchroniser, stable counter, clean level and edge pulses.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int   COUNTER_MAX = 16,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_en,
  input  logic noisy,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int            CW       = cnt_w(COUNTER_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(COUNTER_MAX - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          stable_diff;

  // Only a settled synchroniser that disagrees with the clean level may count.
  assign stable_diff = (sync1 == sync2) && (sync2 != clean);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= RESET_VAL;
      sync2 <= RESET_VAL;
      clean <= RESET_VAL;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= noisy;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (!stable_diff) begin
        cnt <= '0;
      end else if (sample_en) begin
        if (cnt == CNT_LAST) begin
          clean <= sync2;
          cnt   <= '0;
          rise  <= sync2;
          fall  <= ~sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/debounce_multi.sv
// Array of independent debounce channels sharing one clock, reset and sample tick.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int                  CHANNELS    = 8,
  parameter int                  COUNTER_MAX = 16,
  parameter logic [CHANNELS-1:0] RESET_VAL   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_en,
  input  logic [CHANNELS-1:0] noisy_in,
  output logic [CHANNELS-1:0] clean_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                any_change
);

  if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
    $error("debounce_multi: CHANNELS=%0d outside 1..%0d", CHANNELS, MAX_CHANNELS);
  end

  if (COUNTER_MAX < MIN_COUNTER_MAX || COUNTER_MAX > MAX_COUNTER_MAX) begin : g_bad_counter_max
    $error("debounce_multi: COUNTER_MAX=%0d outside %0d..%0d",
           COUNTER_MAX, MIN_COUNTER_MAX, MAX_COUNTER_MAX);
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_ch #(
      .COUNTER_MAX (COUNTER_MAX),
      .RESET_VAL   (RESET_VAL[i])
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_en (sample_en),
      .noisy     (noisy_in[i]),
      .clean     (clean_out[i]),
      .rise      (rise_pulse[i]),
      .fall      (fall_pulse[i])
    );
  end

  assign any_change = |{rise_pulse, fall_pulse};

endmodule

// File: tb/tb_debounce_multi.sv
// Directed scenarios plus randomized traffic checked against a tick-counting reference model.
module tb_debounce_multi;

  localparam int             CH   = 4;
  localparam int             CMAX = 4;
  localparam logic [CH-1:0]  RV_A = 4'b0000;
  localparam logic [CH-1:0]  RV_B = 4'b0101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, sample_en, any_change;
  logic [CH-1:0] noisy_in, clean_out, rise_pulse, fall_pulse;
  logic          rst_n_b, sample_en_b, any_change_b;
  logic [CH-1:0] noisy_in_b, clean_out_b, rise_pulse_b, fall_pulse_b;

  debounce_multi #(.CHANNELS(CH), .COUNTER_MAX(CMAX), .RESET_VAL(RV_A)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_en  (sample_en),
    .noisy_in   (noisy_in),
    .clean_out  (clean_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .any_change (any_change)
  );

  debounce_multi #(.CHANNELS(CH), .COUNTER_MAX(CMAX), .RESET_VAL(RV_B)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n_b),
    .sample_en  (sample_en_b),
    .noisy_in   (noisy_in_b),
    .clean_out  (clean_out_b),
    .rise_pulse (rise_pulse_b),
    .fall_pulse (fall_pulse_b),
    .any_change (any_change_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model for dut: the input as seen two samples late must be steady and
  // differ from the accepted level for CMAX sample ticks in a row before it is taken.
  logic [CH-1:0] m_h1 = RV_A, m_h2 = RV_A, m_clean = RV_A, m_rise = '0, m_fall = '0;
  int            m_ticks [CH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_h1    <= RV_A;
      m_h2    <= RV_A;
      m_clean <= RV_A;
      m_rise  <= '0;
      m_fall  <= '0;
      for (int i = 0; i < CH; i++) m_ticks[i] <= 0;
    end else begin
      m_h1   <= noisy_in;
      m_h2   <= m_h1;
      m_rise <= '0;
      m_fall <= '0;
      for (int i = 0; i < CH; i++) begin
        if (m_h1[i] == m_h2[i] && m_h2[i] != m_clean[i]) begin
          if (sample_en) begin
            if (m_ticks[i] + 1 >= CMAX) begin
              m_clean[i] <= m_h2[i];
              m_ticks[i] <= 0;
              if (m_h2[i]) m_rise[i] <= 1'b1;
              else         m_fall[i] <= 1'b1;
            end else begin
              m_ticks[i] <= m_ticks[i] + 1;
            end
          end
        end else begin
          m_ticks[i] <= 0;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1; rst_n_b = 1'b1;
    sample_en = 1'b1; sample_en_b = 1'b1;
    noisy_in = '0; noisy_in_b = RV_B;

    // Asynchronous reset with no clock edge involved.
    #3; rst_n = 1'b0; rst_n_b = 1'b0;
    #1;
    chk("rst_clean", clean_out, RV_A);
    chk("rst_rise", rise_pulse, 4'b0);
    chk("rst_fall", fall_pulse, 4'b0);
    chk("rst_any", any_change, 1'b0);
    chk("rst_clean_b", clean_out_b, RV_B);

    noisy_in = 4'b1111;
    repeat (3) step();
    chk("rst_hold_clean", clean_out, RV_A);
    chk("rst_hold_rise", rise_pulse, 4'b0);
    noisy_in = '0;
    repeat (2) step();
    rst_n = 1'b1; rst_n_b = 1'b1;
    repeat (4) step();
    chk("idle_clean", clean_out, 4'b0);
    chk("idle_any", any_change, 1'b0);

    // Scenario 1: single rise, accepted on edge CMAX+1.
    noisy_in[0] = 1'b1;
    for (int e = 0; e <= 7; e++) begin
      step();
      chk($sformatf("s1_clean_e%0d", e), clean_out[0], e >= 5);
      chk($sformatf("s1_rise_e%0d", e), rise_pulse[0], e == 5);
      chk($sformatf("s1_any_e%0d", e), any_change, e == 5);
      chk($sformatf("s1_fall_e%0d", e), fall_pulse, 4'b0);
    end

    // Scenario 2: 3-clk glitch is rejected.
    noisy_in[1] = 1'b1;
    for (int e = 0; e <= 11; e++) begin
      if (e == 3) noisy_in[1] = 1'b0;
      step();
      chk($sformatf("s2_clean_e%0d", e), clean_out[1], 1'b0);
      chk($sformatf("s2_pulse_e%0d", e), {rise_pulse, fall_pulse}, 8'b0);
    end

    // Scenario 3: sample tick one clk in four; acceptance on the 4th qualifying tick (edge 15).
    noisy_in[2] = 1'b1;
    for (int e = 0; e <= 17; e++) begin
      sample_en = (e % 4 == 3);
      step();
      chk($sformatf("s3_clean_e%0d", e), clean_out[2], e >= 15);
      chk($sformatf("s3_rise_e%0d", e), rise_pulse[2], e == 15);
    end
    sample_en = 1'b1;

    // Scenario 6: falling acceptance on channel 2.
    noisy_in[2] = 1'b0;
    for (int e = 0; e <= 7; e++) begin
      step();
      chk($sformatf("s6_clean_e%0d", e), clean_out[2], e < 5);
      chk($sformatf("s6_fall_e%0d", e), fall_pulse[2], e == 5);
      chk($sformatf("s6_rise_e%0d", e), rise_pulse, 4'b0);
    end

    noisy_in[0] = 1'b0;
    repeat (8) step();
    chk("pre_s4_clean", clean_out, 4'b0000);

    // Scenario 4: simultaneous acceptance on channels 0 and 3.
    noisy_in = 4'b1001;
    for (int e = 0; e <= 7; e++) begin
      step();
      chk($sformatf("s4_rise_e%0d", e), rise_pulse, (e == 5) ? 4'b1001 : 4'b0000);
      chk($sformatf("s4_any_e%0d", e), any_change, e == 5);
    end
    chk("s4_clean", clean_out, 4'b1001);

    // Scenario 5: reset mid-count on the RESET_VAL=0101 instance.
    noisy_in_b = 4'b1010;
    repeat (3) step();
    #2; rst_n_b = 1'b0;
    #1;
    chk("s5_async_clean", clean_out_b, RV_B);
    chk("s5_async_pulse", {rise_pulse_b, fall_pulse_b}, 8'b0);
    chk("s5_async_any", any_change_b, 1'b0);
    repeat (2) step();
    chk("s5_hold_clean", clean_out_b, RV_B);
    rst_n_b = 1'b1;
    for (int e = 0; e <= 7; e++) begin
      step();
      chk($sformatf("s5_rise_e%0d", e), rise_pulse_b, (e == 5) ? 4'b1010 : 4'b0000);
      chk($sformatf("s5_fall_e%0d", e), fall_pulse_b, (e == 5) ? 4'b0101 : 4'b0000);
      chk($sformatf("s5_clean_e%0d", e), clean_out_b, (e >= 5) ? 4'b1010 : RV_B);
    end

    // Randomized traffic against the reference model.
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 5) == 0) noisy_in[i] = ~noisy_in[i];
      sample_en = ($urandom_range(0, 3) != 0);
      step();
      chk($sformatf("rnd_clean_c%0d", c), clean_out, m_clean);
      chk($sformatf("rnd_rise_c%0d", c), rise_pulse, m_rise);
      chk($sformatf("rnd_fall_c%0d", c), fall_pulse, m_fall);
      chk($sformatf("rnd_any_c%0d", c), any_change, |{m_rise, m_fall});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 8: number of independent input channels, legal range 1..32.
REQ-002 SHALL have parameter COUNTER_MAX, default 16: number of consecutive stable sample ticks required to accept a new level, legal range 2..65536.
REQ-003 SHALL have parameter RESET_VAL [CHANNELS-1:0], default all zeros: per-channel level loaded at reset.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising-edge; all state in this clock domain.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port sample_en, input, 1 bit: sample tick; counters advance only when high.
REQ-007 SHALL have port noisy_in, input, CHANNELS bits: asynchronous raw inputs.
REQ-008 SHALL have port clean_out, output, CHANNELS bits: debounced levels, registered.
REQ-009 SHALL have port rise_pulse, output, CHANNELS bits: one-clk pulse when clean_out goes 0->1.
REQ-010 SHALL have port fall_pulse, output, CHANNELS bits: one-clk pulse when clean_out goes 1->0.
REQ-011 SHALL have port any_change, output, 1 bit: OR of all rise_pulse and fall_pulse bits.

Function
REQ-012 Each channel SHALL pass noisy_in[i] through a 2-flop synchroniser (sync1 -> sync2) every clk, independent of sample_en.
REQ-013 Each channel SHALL hold a stable counter of width $clog2(COUNTER_MAX).
REQ-014 The counter SHALL clear to 0 on any clk where sync2 == clean_out[i] or sync1 != sync2.
REQ-015 Otherwise, with sample_en=1 and counter < COUNTER_MAX-1, the counter SHALL increment by 1; with sample_en=0 it SHALL hold.
REQ-016 With sample_en=1, sync2 != clean_out[i], sync1 == sync2 and counter == COUNTER_MAX-1, on that edge: clean_out[i] <= sync2; counter <= 0; rise_pulse[i] or fall_pulse[i] <= 1 according to the direction of change.
REQ-017 rise_pulse and fall_pulse SHALL be registered, SHALL be high for exactly one clk coincident with the first cycle of the new clean_out value, and SHALL be 0 otherwise.
REQ-018 Latency with sample_en held at 1: define edge 0 as the edge where sync1 first captures the new stable level; clean_out SHALL change on edge COUNTER_MAX+1.
REQ-019 A glitch shorter than the acceptance window SHALL produce no change on clean_out and no pulse; the count restarts from 0 after the glitch.
REQ-020 Channels SHALL be fully independent; simultaneous acceptance on several channels SHALL assert all corresponding pulse bits in the same cycle.
REQ-021 The counter SHALL never exceed COUNTER_MAX-1 and SHALL never wrap.
REQ-022 any_change SHALL be combinational from the registered pulse bits and SHALL add no latency.

Reset
REQ-023 While rst_n=0: sync1, sync2 and clean_out SHALL equal RESET_VAL; counters, rise_pulse, fall_pulse and any_change SHALL be 0.
REQ-024 Reset assertion SHALL take effect immediately, with no clock required, including in the middle of a count; deassertion SHALL produce no spurious pulse.
REQ-025 After deassertion, an input that differs from RESET_VAL SHALL be accepted under the normal timing of REQ-018.

Structure
REQ-026 The shared package debounce_pkg SHALL hold MAX_CHANNELS=32 and a counter-width function cnt_w(COUNTER_MAX).
REQ-027 The block SHALL be built from a generate loop of CHANNELS instances of sub-module debounce_ch (synchroniser, counter, clean flop, edge pulses).
REQ-028 Parameter legality SHALL be checked at elaboration, with an error for out-of-range CHANNELS or COUNTER_MAX.

Verification
REQ-029 Scenario 1: CHANNELS=4, COUNTER_MAX=4, sample_en=1; raise noisy_in[0] at edge 0. Required: clean_out[0]=1 and rise_pulse[0]=1 on edge 5 only; any_change=1 for that one cycle.
REQ-030 Scenario 2: hold noisy_in[1] high for 3 clk, then low. Required: clean_out[1] stays 0; no pulse.
REQ-031 Scenario 3: sample_en high 1 clk in every 4, COUNTER_MAX=4, stable input change. Required: acceptance after the 4th qualifying tick; no acceptance earlier.
REQ-032 Scenario 4: change channels 0 and 3 in the same cycle. Required: rise_pulse=4'b1001 in a single cycle.
REQ-033 Scenario 5: assert rst_n=0 mid-count with RESET_VAL=4'b0101. Required: clean_out=4'b0101 asynchronously; counters 0; no pulse after release.
REQ-034 Scenario 6: clean_out[2]=1, then hold input low. Required: fall_pulse[2]=1 for one clk on edge COUNTER_MAX+1; rise_pulse=0.
